// File: rtl/ssd1306_rx_pkg.sv
// Shared opcodes, enums and helpers for the SSD1306 SPI receiver.
// Defines parser states, address modes and the command argument count.
package ssd1306_rx_pkg;

   localparam int BYTE_BITS = 8;

   localparam logic [7:0] OP_MEM_MODE  = 8'h20;
   localparam logic [7:0] OP_COL_ADDR  = 8'h21;
   localparam logic [7:0] OP_PAGE_ADDR = 8'h22;
   localparam logic [7:0] OP_CONTRAST  = 8'h81;
   localparam logic [7:0] OP_CHG_PUMP  = 8'h8D;
   localparam logic [7:0] OP_NORMAL    = 8'hA6;
   localparam logic [7:0] OP_INVERT    = 8'hA7;
   localparam logic [7:0] OP_MUX_RATIO = 8'hA8;
   localparam logic [7:0] OP_DISP_OFF  = 8'hAE;
   localparam logic [7:0] OP_DISP_ON   = 8'hAF;
   localparam logic [7:0] OP_DISP_OFS  = 8'hD3;
   localparam logic [7:0] OP_CLK_DIV   = 8'hD5;
   localparam logic [7:0] OP_PRECHG    = 8'hD9;
   localparam logic [7:0] OP_COM_PINS  = 8'hDA;
   localparam logic [7:0] OP_VCOMH     = 8'hDB;

   typedef enum logic [1:0] {
      HORIZ = 2'b00,
      VERT  = 2'b01,
      PAGE  = 2'b10
   } addr_mode_t;

   typedef enum logic [1:0] {
      IDLE,
      ARG1,
      ARG2
   } pstate_t;

   function automatic logic [1:0] arg_count(input logic [7:0] op);
      case (op)
         OP_COL_ADDR, OP_PAGE_ADDR:
            arg_count = 2'd2;
         OP_MEM_MODE, OP_CONTRAST, OP_CHG_PUMP,
         OP_MUX_RATIO, OP_DISP_OFS, OP_CLK_DIV,
         OP_PRECHG, OP_COM_PINS, OP_VCOMH:
            arg_count = 2'd1;
         default:
            arg_count = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/ssd1306_spi_deser.sv
// SPI mode-0 deserialiser: synchronisers, SCLK edge detect, shifter, frame error.
// In: sclk/sdin/dc/ss/res, proto_err. Out: res_s, rx_byte, rx_is_data, rx_valid, frame_err.
module ssd1306_spi_deser
   import ssd1306_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       oled_sclk,
   input  logic       oled_sdin,
   input  logic       oled_dc,
   input  logic       ss,
   input  logic       oled_res,
   input  logic       proto_err,
   output logic       res_s,
   output logic [7:0] rx_byte,
   output logic       rx_is_data,
   output logic       rx_valid,
   output logic       frame_err
);

   // lane order: {res, ss, dc, sdin, sclk}
   logic [SYNC_STAGES-1:0][4:0] sy;
   logic [4:0] s;
   logic       sclk_q;
   logic       ss_q;
   logic [2:0] cnt;
   logic [6:0] shreg;

   assign s     = sy[SYNC_STAGES-1];
   assign res_s = s[4];

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         sy         <= '0;
         sclk_q     <= 1'b0;
         ss_q       <= 1'b0;
         cnt        <= '0;
         shreg      <= '0;
         rx_byte    <= '0;
         rx_is_data <= 1'b0;
         rx_valid   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         sy <= {sy[SYNC_STAGES-2:0],
                {oled_res, ss, oled_dc, oled_sdin, oled_sclk}};
         sclk_q <= s[0];
         ss_q   <= s[3];
         if (!s[4]) begin
            cnt        <= '0;
            shreg      <= '0;
            rx_byte    <= '0;
            rx_is_data <= 1'b0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
         end else begin
            rx_valid <= 1'b0;
            if (s[3]) begin
               cnt <= '0;
               // deselect in mid-byte drops the partial byte
               if (!ss_q && cnt != '0)
                  frame_err <= 1'b1;
            end else if (s[0] && !sclk_q) begin
               shreg <= {shreg[5:0], s[1]};
               cnt   <= cnt + 3'd1;
               if (cnt == 3'(BYTE_BITS - 1)) begin
                  rx_byte    <= {shreg, s[1]};
                  rx_is_data <= s[2];
                  rx_valid   <= 1'b1;
               end
            end
            if (ss_q && !s[3])
               frame_err <= 1'b0;
            if (proto_err)
               frame_err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/ssd1306_spi_rx.sv
// SSD1306 SPI receiver: command parser, display state mirror, GDDRAM address.
// Full address tracking only with SSD1306_RX_ADDR_TRACK_EN; else ram_col/ram_page = 0.
module ssd1306_spi_rx
   import ssd1306_rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int COLS        = 128,
   parameter int PAGES       = 8
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       oled_sclk,
   input  logic       oled_sdin,
   input  logic       oled_dc,
   input  logic       ss,
   input  logic       oled_res,
   output logic [7:0] rx_byte,
   output logic       rx_is_data,
   output logic       rx_valid,
   output logic [7:0] cmd_code,
   output logic [7:0] cmd_arg0,
   output logic [7:0] cmd_arg1,
   output logic       cmd_valid,
   output logic       display_on,
   output logic       inverted,
   output logic [7:0] contrast,
   output logic       ram_we,
   output logic [6:0] ram_col,
   output logic [2:0] ram_page,
   output logic       frame_err
);

   logic       res_s;
   logic       perr;
   logic       fin;
   logic [7:0] fin_code;
   logic [7:0] fin_a0;
   logic [7:0] fin_a1;
   logic [7:0] code_q;
   logic [7:0] arg0_q;
   pstate_t    st;
   pstate_t    nxt;

   ssd1306_spi_deser #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_deser (
      .clk_50M   (clk_50M),
      .rst_n     (rst_n),
      .oled_sclk (oled_sclk),
      .oled_sdin (oled_sdin),
      .oled_dc   (oled_dc),
      .ss        (ss),
      .oled_res  (oled_res),
      .proto_err (perr),
      .res_s     (res_s),
      .rx_byte   (rx_byte),
      .rx_is_data(rx_is_data),
      .rx_valid  (rx_valid),
      .frame_err (frame_err)
   );

   // data bytes always hit RAM, even when they abort a command
   assign ram_we = rx_valid & rx_is_data;

   always_comb begin
      nxt      = st;
      fin      = 1'b0;
      fin_code = code_q;
      fin_a0   = arg0_q;
      fin_a1   = '0;
      perr     = 1'b0;
      if (rx_valid) begin
         if (rx_is_data) begin
            nxt  = IDLE;
            perr = (st != IDLE);
         end else begin
            unique case (st)
               IDLE: begin
                  fin_code = rx_byte;
                  fin_a0   = '0;
                  if (arg_count(rx_byte) == 2'd0)
                     fin = 1'b1;
                  else
                     nxt = ARG1;
               end
               ARG1: begin
                  fin_a0 = rx_byte;
                  if (arg_count(code_q) == 2'd1) begin
                     fin = 1'b1;
                     nxt = IDLE;
                  end else begin
                     nxt = ARG2;
                  end
               end
               ARG2: begin
                  fin_a1 = rx_byte;
                  fin    = 1'b1;
                  nxt    = IDLE;
               end
               default: nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         st         <= IDLE;
         code_q     <= '0;
         arg0_q     <= '0;
         cmd_valid  <= 1'b0;
         cmd_code   <= '0;
         cmd_arg0   <= '0;
         cmd_arg1   <= '0;
         display_on <= 1'b0;
         inverted   <= 1'b0;
         contrast   <= 8'h7F;
      end else if (!res_s) begin
         st         <= IDLE;
         code_q     <= '0;
         arg0_q     <= '0;
         cmd_valid  <= 1'b0;
         cmd_code   <= '0;
         cmd_arg0   <= '0;
         cmd_arg1   <= '0;
         display_on <= 1'b0;
         inverted   <= 1'b0;
         contrast   <= 8'h7F;
      end else begin
         st        <= nxt;
         cmd_valid <= fin;
         if (rx_valid && !rx_is_data) begin
            if (st == IDLE) code_q <= rx_byte;
            if (st == ARG1) arg0_q <= rx_byte;
         end
         if (fin) begin
            cmd_code <= fin_code;
            cmd_arg0 <= fin_a0;
            cmd_arg1 <= fin_a1;
            unique case (1'b1)
               fin_code == OP_DISP_OFF: display_on <= 1'b0;
               fin_code == OP_DISP_ON:  display_on <= 1'b1;
               fin_code == OP_NORMAL:   inverted   <= 1'b0;
               fin_code == OP_INVERT:   inverted   <= 1'b1;
               fin_code == OP_CONTRAST: contrast   <= fin_a0;
               default: ;
            endcase
         end
      end
   end

`ifdef SSD1306_RX_ADDR_TRACK_EN
   addr_mode_t mode;
   logic [6:0] col, col_s, col_e;
   logic [2:0] pg, pg_s, pg_e;

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         mode  <= PAGE;
         col   <= '0;
         col_s <= '0;
         col_e <= 7'(COLS - 1);
         pg    <= '0;
         pg_s  <= '0;
         pg_e  <= 3'(PAGES - 1);
      end else if (!res_s) begin
         mode  <= PAGE;
         col   <= '0;
         col_s <= '0;
         col_e <= 7'(COLS - 1);
         pg    <= '0;
         pg_s  <= '0;
         pg_e  <= 3'(PAGES - 1);
      end else if (ram_we) begin
         case (mode)
            HORIZ: begin
               if (col == col_e) begin
                  col <= col_s;
                  pg  <= (pg == pg_e) ? pg_s : pg + 3'd1;
               end else begin
                  col <= col + 7'd1;
               end
            end
            VERT: begin
               if (pg == pg_e) begin
                  pg  <= pg_s;
                  col <= (col == col_e) ? col_s : col + 7'd1;
               end else begin
                  pg <= pg + 3'd1;
               end
            end
            default:
               col <= (col == 7'(COLS - 1)) ? '0 : col + 7'd1;
         endcase
      end else if (fin) begin
         unique case (1'b1)
            fin_code == OP_MEM_MODE:
               if (fin_a0[1:0] != 2'b11)
                  mode <= addr_mode_t'(fin_a0[1:0]);
            fin_code == OP_COL_ADDR: begin
               col_s <= fin_a0[6:0];
               col_e <= fin_a1[6:0];
               col   <= fin_a0[6:0];
            end
            fin_code == OP_PAGE_ADDR: begin
               pg_s <= fin_a0[2:0];
               pg_e <= fin_a1[2:0];
               pg   <= fin_a0[2:0];
            end
            fin_code[7:4] == 4'h0: col[3:0] <= fin_code[3:0];
            fin_code[7:3] == 5'h02: col[6:4] <= fin_code[2:0];
            fin_code[7:3] == 5'h16: pg <= fin_code[2:0];
            default: ;
         endcase
      end
   end

   assign ram_col  = col;
   assign ram_page = pg;
`else
   assign ram_col  = '0;
   assign ram_page = '0;
`endif

endmodule
